// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: bubble encoding, reset PC,
// jump-select encodings and the fetch FSM state type.
package mips_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_DROP     = 2'd1,
    ST_BUFFERED = 2'd2
  } fetch_state_t;

  // The reserved encoding 2'b11 falls into the jr case through jump[1].
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  jump,
    input logic [31:0] branch_target,
    input logic [31:0] jump_target,
    input logic [31:0] jr_target
  );
    if (jump[1])
      return jr_target;
    else if (jump == JMP_J)
      return jump_target;
    return branch_target;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold / flush / load controls. Anything other than
// a load while not held writes a bubble (NOP, invalid).
module if_id_reg #(
  parameter logic [31:0] NOP = mips_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load && !flush) begin
        instr <= next_instr;
        pc4   <= next_pc4;
        valid <= 1'b1;
      end else begin
        instr <= NOP;
        pc4   <= 32'h0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, imem req/ack handshake, redirect
// handling and a one-entry buffer for responses that arrive while ID is held.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = mips_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        hazard,
  input  logic [1:0]  jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_IFID,
  output logic [31:0] pc4_IFID,
  output logic        valid_IFID
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_addr_reg, fetch_addr_next;
  logic [31:0]  redirect_pc_reg, redirect_pc_next;
  logic [31:0]  buf_instr_reg, buf_instr_next;
  logic [31:0]  buf_pc4_reg, buf_pc4_next;
  logic         buf_valid_reg, buf_valid_next;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  addr_plus4;
  logic         ifid_load;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc4;

  // A held redirect is ignored; ID will present it again once released.
  assign redirect   = hazard && !hold;
  assign target     = redirect_target(jump, branch_target, jump_target, jr_target);
  assign addr_plus4 = fetch_addr_reg + 32'd4;

  assign imem_req  = !rst && (state_reg != ST_BUFFERED);
  assign imem_addr = fetch_addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_FETCH;
      fetch_addr_reg  <= RESET_PC;
      redirect_pc_reg <= 32'h0;
      buf_instr_reg   <= NOP;
      buf_pc4_reg     <= 32'h0;
      buf_valid_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_addr_reg  <= fetch_addr_next;
      redirect_pc_reg <= redirect_pc_next;
      buf_instr_reg   <= buf_instr_next;
      buf_pc4_reg     <= buf_pc4_next;
      buf_valid_reg   <= buf_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_addr_next  = fetch_addr_reg;
    redirect_pc_next = redirect_pc_reg;
    buf_instr_next   = buf_instr_reg;
    buf_pc4_next     = buf_pc4_reg;
    buf_valid_next   = buf_valid_reg;
    ifid_load        = 1'b0;
    ifid_instr       = imem_rdata;
    ifid_pc4         = addr_plus4;

    case (state_reg)
      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_addr_next = target;
          end else begin
            fetch_addr_next = addr_plus4;
            if (hold) begin
              buf_instr_next = imem_rdata;
              buf_pc4_next   = addr_plus4;
              buf_valid_next = 1'b1;
              state_next     = ST_BUFFERED;
            end else begin
              ifid_load = 1'b1;
            end
          end
        end else if (redirect) begin
          redirect_pc_next = target;
          state_next       = ST_DROP;
        end
      end

      ST_DROP: begin
        if (redirect)
          redirect_pc_next = target;
        // The stale response is discarded; the newest redirect wins.
        if (imem_ack) begin
          fetch_addr_next = redirect ? target : redirect_pc_reg;
          state_next      = ST_FETCH;
        end
      end

      ST_BUFFERED: begin
        ifid_instr = buf_instr_reg;
        ifid_pc4   = buf_pc4_reg;
        if (redirect) begin
          buf_valid_next  = 1'b0;
          fetch_addr_next = target;
          state_next      = ST_FETCH;
        end else if (!hold) begin
          ifid_load      = buf_valid_reg;
          buf_valid_next = 1'b0;
          state_next     = ST_FETCH;
        end
      end

      default: state_next = ST_FETCH;
    endcase
  end

  if_id_reg #(.NOP(NOP)) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (redirect),
    .load       (ifid_load),
    .next_instr (ifid_instr),
    .next_pc4   (ifid_pc4),
    .instr      (instr_IFID),
    .pc4        (pc4_IFID),
    .valid      (valid_IFID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns the address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        hazard;
  logic [1:0]  jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_IFID;
  logic [31:0] pc4_IFID;
  logic        valid_IFID;
  logic        ack_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && ack_en;
  assign imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .hazard        (hazard),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_IFID    (instr_IFID),
    .pc4_IFID      (pc4_IFID),
    .valid_IFID    (valid_IFID)
  );

  typedef struct {
    logic        hold;
    logic        hazard;
    logic [1:0]  jump;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic h, input logic z, input logic [1:0] j,
                              input logic a, input logic r, input logic [31:0] ad,
                              input logic [31:0] ins, input logic [31:0] p4,
                              input logic v);
    vec_t t;
    t.hold = h; t.hazard = z; t.jump = j; t.ack = a;
    t.exp_req = r; t.exp_addr = ad; t.exp_instr = ins; t.exp_pc4 = p4; t.exp_valid = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic [31:0] ad,
                           input logic [31:0] ins, input logic [31:0] p4, input logic v);
    check({tag, ".imem_req"},   {31'b0, imem_req},   {31'b0, r});
    check({tag, ".imem_addr"},  imem_addr,           ad);
    check({tag, ".instr_IFID"}, instr_IFID,          ins);
    check({tag, ".pc4_IFID"},   pc4_IFID,            p4);
    check({tag, ".valid_IFID"}, {31'b0, valid_IFID}, {31'b0, v});
  endtask

  initial begin
    // Row k: inputs for cycle k; IF/ID expectations reflect the edge ending cycle k-1.
    //               hold hz  jump   ack req addr           instr          pc4            v
    vecs[0]  = mk(0, 0, 2'b00, 1, 1, 32'h0000_0000, 32'h0,         32'h0,         0);
    vecs[1]  = mk(0, 0, 2'b00, 1, 1, 32'h0000_0004, 32'h0,         32'h4,         1);
    vecs[2]  = mk(0, 0, 2'b00, 1, 1, 32'h0000_0008, 32'h4,         32'h8,         1);
    vecs[3]  = mk(0, 0, 2'b00, 1, 1, 32'h0000_000C, 32'h8,         32'hC,         1);
    vecs[4]  = mk(1, 0, 2'b00, 1, 1, 32'h0000_0010, 32'hC,         32'h10,        1);
    vecs[5]  = mk(1, 0, 2'b00, 1, 0, 32'h0000_0014, 32'hC,         32'h10,        1);
    vecs[6]  = mk(1, 0, 2'b00, 1, 0, 32'h0000_0014, 32'hC,         32'h10,        1);
    vecs[7]  = mk(0, 0, 2'b00, 1, 0, 32'h0000_0014, 32'hC,         32'h10,        1);
    vecs[8]  = mk(0, 0, 2'b00, 1, 1, 32'h0000_0014, 32'h10,        32'h14,        1);
    vecs[9]  = mk(0, 1, 2'b01, 1, 1, 32'h0000_0018, 32'h14,        32'h18,        1);
    vecs[10] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0400, 32'h0,         32'h0,         0);
    vecs[11] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0404, 32'h400,       32'h404,       1);
    vecs[12] = mk(0, 1, 2'b00, 0, 1, 32'h0000_0408, 32'h404,       32'h408,       1);
    vecs[13] = mk(0, 0, 2'b00, 0, 1, 32'h0000_0408, 32'h0,         32'h0,         0);
    vecs[14] = mk(0, 0, 2'b00, 0, 1, 32'h0000_0408, 32'h0,         32'h0,         0);
    vecs[15] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0408, 32'h0,         32'h0,         0);
    vecs[16] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0080, 32'h0,         32'h0,         0);
    vecs[17] = mk(1, 1, 2'b01, 1, 1, 32'h0000_0084, 32'h80,        32'h84,        1);
    vecs[18] = mk(0, 1, 2'b10, 1, 0, 32'h0000_0088, 32'h80,        32'h84,        1);
    vecs[19] = mk(0, 0, 2'b00, 1, 1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    vecs[20] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1);
    vecs[21] = mk(0, 1, 2'b11, 1, 1, 32'h0000_0004, 32'h0,         32'h4,         1);
    vecs[22] = mk(0, 0, 2'b00, 1, 1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    vecs[23] = mk(0, 0, 2'b00, 0, 1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1);
    vecs[24] = mk(0, 0, 2'b00, 1, 1, 32'h0000_0000, 32'h0,         32'h0,         0);

    rst = 1'b1; hold = 1'b0; hazard = 1'b0; jump = 2'b00; ack_en = 1'b0;
    branch_target = 32'h0000_0080;
    jump_target   = 32'h0000_0400;
    jr_target     = 32'hFFFF_FFFC;

    repeat (2) @(posedge clk);
    #1;
    ack_en = 1'b1;
    #1;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      hold = vecs[k].hold; hazard = vecs[k].hazard; jump = vecs[k].jump; ack_en = vecs[k].ack;
      @(negedge clk);
      check_all($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_addr,
                vecs[k].exp_instr, vecs[k].exp_pc4, vecs[k].exp_valid);
      $display("vec%0d: hold=%0b hazard=%0b jump=%0b ack=%0b req=%0b addr=0x%08h ifid={0x%08h,0x%08h,%0b}",
               k, hold, hazard, jump, ack_en, imem_req, imem_addr, instr_IFID, pc4_IFID, valid_IFID);
      @(posedge clk);
      #1;
    end

    // After vec24's edge IF/ID holds {0,4,1} and a request for 0x4 is out.
    hold = 1'b0; hazard = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    check_all("pre_arst", 1'b1, 32'h4, 32'h0, 32'h4, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_all("arst_pulse", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    $display("arst: req=%0b addr=0x%08h ifid={0x%08h,0x%08h,%0b}",
             imem_req, imem_addr, instr_IFID, pc4_IFID, valid_IFID);
    #1 rst = 1'b0;
    ack_en = 1'b1;
    #1;
    check_all("arst_restart", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_all("arst_first", 1'b1, 32'h4, 32'h0, 32'h4, 1'b1);
    $display("restart: req=%0b addr=0x%08h ifid={0x%08h,0x%08h,%0b}",
             imem_req, imem_addr, instr_IFID, pc4_IFID, valid_IFID);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS32 pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake and drives the IF/ID pipeline register. It consumes the ID-stage hazard unit's `hold` (freeze) and `hazard` (redirect/flush) outputs and its redirect targets. A one-entry buffer absorbs an instruction returned while ID is held.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0000, bubble instruction written on flush
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `hold` in 1: freeze IF/ID; ID cannot accept
- `hazard` in 1: redirect, i.e. taken branch or jump; flush younger fetch
- `jump` in 2: 2'b10 → `jr_target`; 2'b01 → `jump_target`; 2'b00 → `branch_target`; 2'b11 → `jr_target`
- `branch_target`, `jump_target`, `jr_target` in 32 each: redirect addresses
- `imem_req` out 1: request valid
- `imem_addr` out 32: request address
- `imem_ack` in 1: response valid; may be asserted in the same cycle as `imem_req`
- `imem_rdata` in 32: instruction, valid when `imem_ack`=1
- `instr_IFID` out 32: IF/ID instruction
- `pc4_IFID` out 32: fetched address + 4
- `valid_IFID` out 1: IF/ID holds a real instruction

## Operation
- State: `fetch_addr` (drives `imem_addr`), `redirect_pc`, buffer (`buf_instr`, `buf_pc4`, `buf_valid`), FSM.
- FSM states:
  - FETCH: `imem_req`=1.
  - DROP: `imem_req`=1. A stale request is outstanding; its response is discarded.
  - BUFFERED: `imem_req`=0. The buffer is full.
- `imem_addr` and `imem_req` stay stable until `imem_ack`. Requests are never withdrawn.
- A redirect is effective only when `hazard`=1 and `hold`=0. `hold` has priority and a held redirect is ignored.
- Redirect target = `jump[1]` ? `jr_target` : `jump[0]` ? `jump_target` : `branch_target`.
- FETCH:
  - ack, no redirect, `hold`=0: IF/ID ← {rdata, addr+4, 1}. `fetch_addr` += 4.
  - ack, no redirect, `hold`=1: buffer ← {rdata, addr+4}. `fetch_addr` += 4. Go to BUFFERED.
  - ack with redirect: response squashed. `fetch_addr` ← target. IF/ID ← {NOP, 0, 0}.
  - no ack with redirect: `redirect_pc` ← target. IF/ID flushed. Go to DROP.
  - no ack, no redirect, `hold`=0: IF/ID ← bubble (`valid`=0, `instr`=NOP).
- DROP:
  - ack: response discarded. `fetch_addr` ← `redirect_pc`. Go to FETCH.
  - A further redirect overwrites `redirect_pc`.
  - While not held, IF/ID receives bubbles.
- BUFFERED:
  - `hold`=0, no redirect: IF/ID ← buffer. Clear the buffer. Go to FETCH. The new request is issued the next cycle.
  - Redirect: clear the buffer, flush IF/ID. `fetch_addr` ← target. Go to FETCH.
- `hold`=1 in any state: IF/ID unchanged.
- All address arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0.
- Bit pattern of `jump`=2'b11 is reserved; the block treats it as a jr.

## Timing
- Reset values:
  - `imem_req`=0 while `rst` is asserted.
  - `fetch_addr`=`RESET_PC`.
  - FSM=FETCH.
  - `instr_IFID`=NOP, `pc4_IFID`=0, `valid_IFID`=0.
  - Buffer empty, `redirect_pc`=0.
- First request is in the first cycle after `rst` deasserts.
- Latency from request to IF/ID is 1 cycle with same-cycle ack. Throughput is 1 instruction per cycle with always-ack memory.
- Redirect penalty with zero-wait memory: a redirect at cycle N places a request for the target in cycle N+1, and the target is in IF/ID at N+2.
- Reset mid-request drops the outstanding request. Memory must tolerate an abandoned request.
- `hazard` and `hold` are sampled only at the rising edge. No combinational path from `hold`/`hazard` to `imem_req`.

## Structure
- Shared package `mips_pkg`: `NOP`, `RESET_PC` default, the `jump` encodings (`JMP_NONE`, `JMP_J`, `JMP_JR`), and the fetch FSM state enum.
- Sub-module `if_id_reg`: IF/ID register with load/hold/flush controls and NOP insertion. It is reusable for other pipeline registers.
- The FSM, `fetch_addr`/`redirect_pc` and the buffer stay in `fetch_stage`.

## Test plan
- Reset release with always-ack memory returning `addr`-as-data:
  - `imem_addr` reads 0, 4, 8, … on consecutive cycles.
  - `pc4_IFID` reads 4, 8, 12, …, with `valid_IFID`=1 from the second cycle.
- `hold`=1 for 3 cycles while an ack arrives at addr 0x10:
  - IF/ID is frozen and the FSM is in BUFFERED with `imem_req`=0.
  - On release, `instr_IFID`=0x10 and the next request is 0x14.
- `hazard`=1, `jump`=2'b01, `jump_target`=0x400, with ack in the same cycle:
  - IF/ID gets a bubble (`valid_IFID`=0, `instr_IFID`=NOP).
  - The next request is 0x400.
  - `pc4_IFID`=0x404 two cycles later.
- Ack delayed 3 cycles and a `branch_target`=0x80 redirect in the first wait cycle:
  - `imem_addr` stays at the stale address until ack.
  - The stale data never reaches IF/ID.
  - The next request is 0x80.
- `hold`=1 and `hazard`=1 together:
  - No redirect and IF/ID unchanged.
  - A redirect one cycle later with `hold`=0 takes effect.
- `fetch_addr`=0xFFFF_FFFC with an ack:
  - The next request is 0x0000_0000.
- Async `rst` pulse between clock edges mid-request:
  - Outputs take their reset values immediately.
  - Fetch restarts at `RESET_PC`.
